regfile_wb_sink: RTL and testbench

//  Architectural integer register file and write-back sink: consumes the write port driven by the
//  MEM/WB pipeline register (write enable, rd address, rd data) and serves two read ports to ID.

---
 rtl/regfile_wb_sink.sv | 112 +++++++++++
 tb/tb_regfile_wb_sink.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_sink.sv
// Architectural integer register file with write-back sink and RAW scoreboard.
// Consumes the MEM/WB write port, serves two combinational read ports to ID with
// same-cycle WB->ID bypass, and tracks per-register pending writes to flag hazards.
//
// Ports:
//   clk_in, rst_in          clock, synchronous active-high reset
//   rdy_in                  global ready; 0 freezes all state (reads still served)
//   wb_we/wb_waddr/wb_wdata write-back port from MEM/WB
//   re1/raddr1, re2/raddr2  read enables and addresses
//   rdata1, rdata2          read data (combinational, bypassed)
//   busy1, busy2            source register still has an unretired pending write
//   issue_we/issue_rd       ID issues an instruction writing issue_rd
//   sb_err                  sticky: issue attempted on a saturated pending counter
module regfile_wb_sink #(
    parameter int unsigned REG_NUM = 32,
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned CNT_W   = 2
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              wb_we,
    input  logic [ADDR_W-1:0] wb_waddr,
    input  logic [DATA_W-1:0] wb_wdata,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    output logic              busy1,
    output logic              busy2,
    input  logic              issue_we,
    input  logic [ADDR_W-1:0] issue_rd,
    output logic              sb_err
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [DATA_W-1:0] r_regs [REG_NUM];
    logic [CNT_W-1:0]  r_cnt  [REG_NUM];
    logic              r_sb_err;

    logic w_inc;
    logic w_dec;
    logic w_hit1;
    logic w_hit2;

    // x0 destinations neither allocate nor retire a pending write
    assign w_inc = issue_we && (issue_rd != '0);
    assign w_dec = wb_we && (wb_waddr != '0);

    // Bypass is only live when the write will actually commit this edge
    assign w_hit1 = wb_we && rdy_in && (wb_waddr == raddr1);
    assign w_hit2 = wb_we && rdy_in && (wb_waddr == raddr2);

    assign sb_err = r_sb_err;

    // Register storage, pending-write counters and sticky error
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int unsigned r = 0; r < REG_NUM; r++) begin
                r_regs[r] <= '0;
                r_cnt[r]  <= '0;
            end
            r_sb_err <= 1'b0;
        end else if (rdy_in) begin
            if (w_dec) begin
                r_regs[wb_waddr] <= wb_wdata;
            end
            for (int unsigned r = 1; r < REG_NUM; r++) begin
                // Matching issue and retire on the same register cancel out
                if (w_inc && (issue_rd == ADDR_W'(r)) &&
                    !(w_dec && (wb_waddr == ADDR_W'(r)))) begin
                    if (r_cnt[r] == CNT_MAX) begin
                        r_sb_err <= 1'b1;
                    end else begin
                        r_cnt[r] <= r_cnt[r] + CNT_W'(1);
                    end
                end else if (w_dec && (wb_waddr == ADDR_W'(r)) &&
                             !(w_inc && (issue_rd == ADDR_W'(r)))) begin
                    // Stray write-backs (e.g. in flight across reset) are absorbed at 0
                    if (r_cnt[r] != '0) begin
                        r_cnt[r] <= r_cnt[r] - CNT_W'(1);
                    end
                end
            end
        end
    end

    // Read port 1 with WB bypass; a retiring last write does not count as busy
    always_comb begin
        rdata1 = '0;
        busy1  = 1'b0;
        if (re1 && (raddr1 != '0)) begin
            rdata1 = w_hit1 ? wb_wdata : r_regs[raddr1];
            busy1  = r_cnt[raddr1] > CNT_W'(w_hit1);
        end
    end

    // Read port 2, identical to port 1
    always_comb begin
        rdata2 = '0;
        busy2  = 1'b0;
        if (re2 && (raddr2 != '0)) begin
            rdata2 = w_hit2 ? wb_wdata : r_regs[raddr2];
            busy2  = r_cnt[raddr2] > CNT_W'(w_hit2);
        end
    end

endmodule

// File: tb/tb_regfile_wb_sink.sv
// Bench for regfile_wb_sink: directed vector table plus randomized traffic
// checked against an array-based reference model.
module tb_regfile_wb_sink;

    localparam int unsigned REG_NUM = 32;
    localparam int unsigned ADDR_W  = 5;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned CNT_W   = 2;
    localparam int          CMAX    = (1 << CNT_W) - 1;

    logic              clk_in;
    logic              rst_in;
    logic              rdy_in;
    logic              wb_we;
    logic [ADDR_W-1:0] wb_waddr;
    logic [DATA_W-1:0] wb_wdata;
    logic              re1;
    logic [ADDR_W-1:0] raddr1;
    logic              re2;
    logic [ADDR_W-1:0] raddr2;
    logic [DATA_W-1:0] rdata1;
    logic [DATA_W-1:0] rdata2;
    logic              busy1;
    logic              busy2;
    logic              issue_we;
    logic [ADDR_W-1:0] issue_rd;
    logic              sb_err;

    regfile_wb_sink #(
        .REG_NUM(REG_NUM), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
        .re1(re1), .raddr1(raddr1), .re2(re2), .raddr2(raddr2),
        .rdata1(rdata1), .rdata2(rdata2), .busy1(busy1), .busy2(busy2),
        .issue_we(issue_we), .issue_rd(issue_rd), .sb_err(sb_err)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    int checks = 0;
    int errors = 0;

    // Reference model: architectural values, pending-write counts, sticky error
    logic [DATA_W-1:0] m_regs [REG_NUM];
    int                m_cnt  [REG_NUM];
    bit                m_err;

    typedef struct {
        logic              rst;
        logic              rdy;
        logic              we;
        logic [ADDR_W-1:0] wa;
        logic [DATA_W-1:0] wd;
        logic              r1;
        logic [ADDR_W-1:0] a1;
        logic              r2;
        logic [ADDR_W-1:0] a2;
        logic              iwe;
        logic [ADDR_W-1:0] ird;
        logic [DATA_W-1:0] e_rd1;
        logic              e_b1;
        logic [DATA_W-1:0] e_rd2;
        logic              e_b2;
        logic              e_err;
    } vec_t;

    localparam int NVEC = 22;
    vec_t tbl [NVEC];

    function automatic vec_t mk(logic rst, logic rdy, logic we, int wa, logic [DATA_W-1:0] wd,
                                logic r1, int a1, logic r2, int a2, logic iwe, int ird,
                                logic [DATA_W-1:0] e_rd1, logic e_b1,
                                logic [DATA_W-1:0] e_rd2, logic e_b2, logic e_err);
        vec_t v;
        v.rst = rst; v.rdy = rdy; v.we = we; v.wa = ADDR_W'(wa); v.wd = wd;
        v.r1 = r1; v.a1 = ADDR_W'(a1); v.r2 = r2; v.a2 = ADDR_W'(a2);
        v.iwe = iwe; v.ird = ADDR_W'(ird);
        v.e_rd1 = e_rd1; v.e_b1 = e_b1; v.e_rd2 = e_rd2; v.e_b2 = e_b2; v.e_err = e_err;
        return v;
    endfunction

    task automatic check(input string name, input logic [DATA_W-1:0] act,
                         input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] exp_rdata(logic re, logic [ADDR_W-1:0] a);
        if (!re || a == '0) return '0;
        if (wb_we && rdy_in && wb_waddr == a) return wb_wdata;
        return m_regs[a];
    endfunction

    function automatic logic exp_busy(logic re, logic [ADDR_W-1:0] a);
        int retiring;
        if (!re || a == '0) return 1'b0;
        retiring = (wb_we && rdy_in && wb_waddr == a) ? 1 : 0;
        return (m_cnt[a] - retiring) > 0;
    endfunction

    task automatic check_model(input string tag);
        check({tag, ".rdata1"}, rdata1, exp_rdata(re1, raddr1));
        check({tag, ".rdata2"}, rdata2, exp_rdata(re2, raddr2));
        check({tag, ".busy1"}, DATA_W'(busy1), DATA_W'(exp_busy(re1, raddr1)));
        check({tag, ".busy2"}, DATA_W'(busy2), DATA_W'(exp_busy(re2, raddr2)));
        check({tag, ".sb_err"}, DATA_W'(sb_err), DATA_W'(m_err));
    endtask

    // Advance the model by one edge using the net issue/retire delta per register
    task automatic model_update();
        int delta [REG_NUM];
        if (rst_in) begin
            for (int r = 0; r < int'(REG_NUM); r++) begin
                m_regs[r] = '0;
                m_cnt[r]  = 0;
            end
            m_err = 1'b0;
            return;
        end
        if (!rdy_in) return;
        for (int r = 0; r < int'(REG_NUM); r++) delta[r] = 0;
        if (issue_we && issue_rd != '0) delta[issue_rd] += 1;
        if (wb_we && wb_waddr != '0) begin
            delta[wb_waddr] -= 1;
            m_regs[wb_waddr] = wb_wdata;
        end
        for (int r = 1; r < int'(REG_NUM); r++) begin
            if (delta[r] > 0) begin
                if (m_cnt[r] == CMAX) m_err = 1'b1;
                else m_cnt[r] = m_cnt[r] + 1;
            end else if (delta[r] < 0 && m_cnt[r] > 0) begin
                m_cnt[r] = m_cnt[r] - 1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        model_update();
        #1;
    endtask

    task automatic apply(input vec_t v);
        rst_in = v.rst; rdy_in = v.rdy;
        wb_we = v.we; wb_waddr = v.wa; wb_wdata = v.wd;
        re1 = v.r1; raddr1 = v.a1; re2 = v.r2; raddr2 = v.a2;
        issue_we = v.iwe; issue_rd = v.ird;
    endtask

    initial begin
        for (int r = 0; r < int'(REG_NUM); r++) begin
            m_regs[r] = '0;
            m_cnt[r]  = 0;
        end
        m_err = 1'b0;

        //        rst rdy we wa  wd            r1 a1 r2 a2 iwe ird  e_rd1        b1 e_rd2        b2 err
        tbl[0]  = mk(0, 1, 1, 5, 32'hDEADBEEF, 1, 5, 1, 6, 0, 0, 32'hDEADBEEF, 0, 32'h0,       0, 0);
        tbl[1]  = mk(0, 1, 0, 0, 32'h0,        1, 5, 0, 0, 0, 0, 32'hDEADBEEF, 0, 32'h0,       0, 0);
        tbl[2]  = mk(0, 1, 1, 0, 32'h1234,     1, 0, 0, 0, 1, 0, 32'h0,        0, 32'h0,       0, 0);
        tbl[3]  = mk(0, 1, 0, 0, 32'h0,        1, 0, 1, 0, 0, 0, 32'h0,        0, 32'h0,       0, 0);
        tbl[4]  = mk(0, 1, 0, 0, 32'h0,        1, 7, 0, 0, 1, 7, 32'h0,        0, 32'h0,       0, 0);
        tbl[5]  = mk(0, 1, 0, 0, 32'h0,        1, 7, 0, 0, 1, 7, 32'h0,        1, 32'h0,       0, 0);
        tbl[6]  = mk(0, 1, 1, 7, 32'h11111111, 1, 7, 0, 0, 0, 0, 32'h11111111, 1, 32'h0,       0, 0);
        tbl[7]  = mk(0, 1, 1, 7, 32'h22222222, 1, 7, 1, 7, 0, 0, 32'h22222222, 0, 32'h22222222, 0, 0);
        tbl[8]  = mk(0, 1, 0, 0, 32'h0,        1, 7, 0, 0, 0, 0, 32'h22222222, 0, 32'h0,       0, 0);
        tbl[9]  = mk(0, 1, 0, 0, 32'h0,        1, 9, 0, 0, 1, 9, 32'h0,        0, 32'h0,       0, 0);
        tbl[10] = mk(0, 1, 0, 0, 32'h0,        1, 9, 0, 0, 1, 9, 32'h0,        1, 32'h0,       0, 0);
        tbl[11] = mk(0, 1, 0, 0, 32'h0,        1, 9, 0, 0, 1, 9, 32'h0,        1, 32'h0,       0, 0);
        tbl[12] = mk(0, 1, 0, 0, 32'h0,        1, 9, 0, 0, 1, 9, 32'h0,        1, 32'h0,       0, 0);
        tbl[13] = mk(0, 1, 0, 0, 32'h0,        1, 9, 0, 0, 0, 0, 32'h0,        1, 32'h0,       0, 1);
        tbl[14] = mk(0, 0, 1, 3, 32'h55,       1, 3, 0, 0, 1, 3, 32'h0,        0, 32'h0,       0, 1);
        tbl[15] = mk(0, 1, 0, 0, 32'h0,        1, 3, 0, 0, 0, 0, 32'h0,        0, 32'h0,       0, 1);
        tbl[16] = mk(0, 1, 1, 9, 32'hABCD,     1, 9, 0, 0, 1, 9, 32'hABCD,     1, 32'h0,       0, 1);
        tbl[17] = mk(0, 1, 1, 10, 32'h77,      1, 10, 0, 0, 0, 0, 32'h77,      0, 32'h0,       0, 1);
        tbl[18] = mk(0, 1, 0, 0, 32'h0,        1, 10, 0, 0, 0, 0, 32'h77,      0, 32'h0,       0, 1);
        tbl[19] = mk(0, 1, 0, 0, 32'h0,        0, 9, 1, 9, 0, 0, 32'h0,        0, 32'hABCD,    1, 1);
        tbl[20] = mk(1, 1, 0, 0, 32'h0,        1, 9, 0, 0, 0, 0, 32'hABCD,     1, 32'h0,       0, 1);
        tbl[21] = mk(0, 1, 0, 0, 32'h0,        1, 9, 1, 5, 0, 0, 32'h0,        0, 32'h0,       0, 0);

        // Reset sequence
        apply(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tick();
        tick();
        rst_in = 1'b0;

        // After reset every register reads zero and nothing is busy
        for (int r = 1; r < int'(REG_NUM); r++) begin
            re1 = 1'b1; raddr1 = ADDR_W'(r);
            re2 = 1'b1; raddr2 = ADDR_W'(int'(REG_NUM) - r);
            #2;
            check("post_reset.rdata1", rdata1, '0);
            check("post_reset.rdata2", rdata2, '0);
            check("post_reset.busy", DATA_W'({busy1, busy2}), '0);
            check("post_reset.sb_err", DATA_W'(sb_err), '0);
            tick();
        end

        // Directed multi-cycle scenarios
        for (int i = 0; i < NVEC; i++) begin
            apply(tbl[i]);
            #2;
            check($sformatf("vec%0d.rdata1", i), rdata1, tbl[i].e_rd1);
            check($sformatf("vec%0d.busy1", i), DATA_W'(busy1), DATA_W'(tbl[i].e_b1));
            check($sformatf("vec%0d.rdata2", i), rdata2, tbl[i].e_rd2);
            check($sformatf("vec%0d.busy2", i), DATA_W'(busy2), DATA_W'(tbl[i].e_b2));
            check($sformatf("vec%0d.sb_err", i), DATA_W'(sb_err), DATA_W'(tbl[i].e_err));
            tick();
        end

        // Randomized traffic on a narrow address window to force collisions
        for (int c = 0; c < 4000; c++) begin
            rst_in   = ($urandom_range(0, 299) == 0);
            rdy_in   = ($urandom_range(0, 7) != 0);
            wb_we    = $urandom_range(0, 1) == 1;
            wb_waddr = ADDR_W'($urandom_range(0, 7));
            wb_wdata = DATA_W'($urandom);
            re1      = ($urandom_range(0, 5) != 0);
            raddr1   = ADDR_W'($urandom_range(0, 7));
            re2      = ($urandom_range(0, 5) != 0);
            raddr2   = ($urandom_range(0, 3) == 0) ? raddr1 : ADDR_W'($urandom_range(0, 31));
            issue_we = $urandom_range(0, 1) == 1;
            issue_rd = ($urandom_range(0, 3) == 0) ? wb_waddr : ADDR_W'($urandom_range(0, 7));
            #2;
            check_model($sformatf("rand%0d", c));
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
